// File: rtl/gbc_reg_pkg.sv
// Shared types for the CPU register strobe interface: register indices, request/ALU opcodes, flags.
package gbc_reg_pkg;

    localparam int REG_DW  = 8;
    localparam int REG_NUM = 8;

    typedef enum logic [2:0] {
        REG_A, REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_F
    } reg_idx_e;

    typedef enum logic [1:0] {
        OP_READ, OP_WRITE, OP_RMW, OP_RSVD
    } req_op_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_DEC, ALU_CP
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;

endpackage

// File: rtl/reg_alu8.sv
// Combinational 8-bit ALU for read-modify-write; produces result and {Z,N,H,C}.
module reg_alu8
    import gbc_reg_pkg::*;
(
    input  logic [7:0] i_opnd,
    input  logic [7:0] i_wdata,
    input  alu_op_e    i_op,
    output logic [7:0] o_result,
    output flags_t     o_flags
);
    logic [7:0] w_b;
    logic [8:0] w_add;
    logic [8:0] w_sub;
    logic [4:0] w_hadd;
    logic [4:0] w_hsub;

    // INC/DEC reuse the add/sub paths with a constant operand of one
    assign w_b    = (i_op == ALU_INC || i_op == ALU_DEC) ? 8'h01 : i_wdata;
    assign w_add  = {1'b0, i_opnd} + {1'b0, w_b};
    assign w_sub  = {1'b0, i_opnd} - {1'b0, w_b};
    assign w_hadd = {1'b0, i_opnd[3:0]} + {1'b0, w_b[3:0]};
    assign w_hsub = {1'b0, i_opnd[3:0]} - {1'b0, w_b[3:0]};

    always_comb begin
        o_result  = '0;
        o_flags   = '0;
        case (i_op)
            ALU_ADD: begin
                o_result  = w_add[7:0];
                o_flags.h = w_hadd[4];
                o_flags.c = w_add[8];
            end
            ALU_SUB, ALU_CP: begin
                o_result  = w_sub[7:0];
                o_flags.n = 1'b1;
                o_flags.h = w_hsub[4];
                o_flags.c = w_sub[8];
            end
            ALU_AND: begin
                o_result  = i_opnd & w_b;
                o_flags.h = 1'b1;
            end
            ALU_OR:  o_result = i_opnd | w_b;
            ALU_XOR: o_result = i_opnd ^ w_b;
            ALU_INC: begin
                o_result  = w_add[7:0];
                o_flags.h = w_hadd[4];
            end
            ALU_DEC: begin
                o_result  = w_sub[7:0];
                o_flags.n = 1'b1;
                o_flags.h = w_hsub[4];
            end
            default: o_result = '0;
        endcase
        o_flags.z = (o_result == 8'h00);
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register strobe initiator: sequences read/write/RMW strobes and returns a one-cycle response.
// Optional REG_ACCESS_FLAGS_WB_EN: RMW also writes {Z,N,H,C,4'b0} into F via an extra strobe.
module reg_access_ctrl
    import gbc_reg_pkg::*;
#(
    parameter int NUM_REGS = REG_NUM,
    parameter int DW       = REG_DW
)(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [2:0]             req_reg_i,
    input  logic [2:0]             req_alu_i,
    input  logic [DW-1:0]          req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [DW-1:0]          rsp_data_o,
    output logic [3:0]             rsp_flags_o,
    output logic                   rsp_err_o,
    output logic [NUM_REGS-1:0]    reg_sel_o,
    output logic                   reg_rw_o,
    output logic [DW-1:0]          reg_wdata_o,
    input  logic [NUM_REGS*DW-1:0] reg_rdata_i
);
`ifdef REG_ACCESS_FLAGS_WB_EN
    localparam bit FLG_WB = 1'b1;
`else
    localparam bit FLG_WB = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RD_STB, S_RD_CAP, S_ALU, S_WR_STB, S_FLG_STB, S_RESP
    } state_e;

    state_e              r_state;
    req_op_e             r_op;
    reg_idx_e            r_idx;
    alu_op_e             r_alu;
    logic [DW-1:0]       r_wdata;
    logic [DW-1:0]       r_opnd;
    logic [DW-1:0]       r_res;
    flags_t              r_flags;

    logic [DW-1:0]       w_rd;
    logic [DW-1:0]       w_res;
    flags_t              w_flags;
    logic [NUM_REGS-1:0] w_sel;
    logic [NUM_REGS-1:0] w_fsel;

    assign w_rd   = reg_rdata_i[r_idx*DW +: DW];
    assign w_sel  = NUM_REGS'(1) << r_idx;
    assign w_fsel = NUM_REGS'(1) << REG_F;

    reg_alu8 u_alu (
        .i_opnd   (r_opnd),
        .i_wdata  (r_wdata),
        .i_op     (r_alu),
        .o_result (w_res),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_op        <= OP_READ;
            r_idx       <= REG_A;
            r_alu       <= ALU_ADD;
            r_wdata     <= '0;
            r_opnd      <= '0;
            r_res       <= '0;
            r_flags     <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_flags_o <= '0;
            rsp_err_o   <= 1'b0;
            reg_sel_o   <= '0;
            reg_rw_o    <= 1'b0;
            reg_wdata_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        r_op        <= req_op_e'(req_op_i);
                        r_idx       <= reg_idx_e'(req_reg_i);
                        r_alu       <= alu_op_e'(req_alu_i);
                        r_wdata     <= req_wdata_i;
                        req_ready_o <= 1'b0;
                        case (req_op_e'(req_op_i))
                            OP_READ, OP_RMW: begin
                                r_state   <= S_RD_STB;
                                reg_sel_o <= NUM_REGS'(1) << req_reg_i;
                                reg_rw_o  <= 1'b1;
                            end
                            OP_WRITE: begin
                                r_state     <= S_WR_STB;
                                reg_sel_o   <= NUM_REGS'(1) << req_reg_i;
                                reg_rw_o    <= 1'b0;
                                reg_wdata_o <= req_wdata_i;
                            end
                            default: begin
                                r_state     <= S_RESP;
                                rsp_valid_o <= 1'b1;
                                rsp_err_o   <= 1'b1;
                                rsp_data_o  <= '0;
                                rsp_flags_o <= '0;
                            end
                        endcase
                    end
                end
                S_RD_STB: begin
                    r_state   <= S_RD_CAP;
                    reg_sel_o <= '0;
                    reg_rw_o  <= 1'b0;
                end
                // bank dout is valid one edge after the read strobe, i.e. now
                S_RD_CAP: begin
                    r_opnd <= w_rd;
                    if (r_op == OP_READ) begin
                        r_state     <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= w_rd;
                        rsp_flags_o <= '0;
                        rsp_err_o   <= 1'b0;
                    end else begin
                        r_state <= S_ALU;
                    end
                end
                S_ALU: begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                    if (r_alu != ALU_CP) begin
                        r_state     <= S_WR_STB;
                        reg_sel_o   <= w_sel;
                        reg_rw_o    <= 1'b0;
                        reg_wdata_o <= w_res;
                    end else if (FLG_WB) begin
                        r_state     <= S_FLG_STB;
                        reg_sel_o   <= w_fsel;
                        reg_rw_o    <= 1'b0;
                        reg_wdata_o <= DW'({w_flags, 4'b0000});
                    end else begin
                        r_state     <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= r_opnd;
                        rsp_flags_o <= w_flags;
                        rsp_err_o   <= 1'b0;
                    end
                end
                S_WR_STB: begin
                    reg_sel_o <= '0;
                    if (FLG_WB && r_op == OP_RMW) begin
                        r_state     <= S_FLG_STB;
                        reg_sel_o   <= w_fsel;
                        reg_wdata_o <= DW'({r_flags, 4'b0000});
                    end else begin
                        r_state     <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_data_o  <= (r_op == OP_WRITE) ? r_wdata : r_res;
                        rsp_flags_o <= (r_op == OP_WRITE) ? 4'b0000 : r_flags;
                    end
                end
                S_FLG_STB: begin
                    r_state     <= S_RESP;
                    reg_sel_o   <= '0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_data_o  <= (r_alu == ALU_CP) ? r_opnd : r_res;
                    rsp_flags_o <= r_flags;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    reg_sel_o   <= '0;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Randomised bench for reg_access_ctrl: register-bank environment, transaction-level model, per-cycle compare.
module tb_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_reg;
    logic [2:0]  req_alu;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [7:0]  reg_sel;
    logic        reg_rw;
    logic [7:0]  reg_wdata;
    logic [63:0] reg_rdata;

    always #5 clk = ~clk;

    reg_access_ctrl #(.NUM_REGS(8), .DW(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_reg_i(req_reg), .req_alu_i(req_alu), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err),
        .reg_sel_o(reg_sel), .reg_rw_o(reg_rw), .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata)
    );

`ifdef REG_ACCESS_FLAGS_WB_EN
    localparam int FLG = 1;
`else
    localparam int FLG = 0;
`endif

    // Register bank: write on write strobe, dout refreshed on the edge of a read strobe
    logic [7:0] seed [8];
    logic [7:0] regs [8];
    logic [7:0] dout [8];
    logic [7:0] mreg [8];
    logic       bank_load;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bank_load) begin
                regs[i] <= seed[i];
                dout[i] <= seed[i];
            end else if (reg_sel[i]) begin
                if (reg_rw) dout[i] <= regs[i];
                else        regs[i] <= reg_wdata;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < 8; i++) reg_rdata[i*8 +: 8] = dout[i];
    end

    typedef struct {
        logic [7:0] sel; logic rw; logic [7:0] wd;
        logic v; logic [7:0] d; logic [3:0] f; logic e; logic cd; logic rdy;
    } rec_t;

    rec_t exp_q [$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   last_lat;
    bit   skip_model = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void m_alu(input int a, input int b, input int op,
                                  output int r, output logic [3:0] f);
        int rr; bit n, h, c;
        n = 0; h = 0; c = 0;
        case (op)
            0: begin rr = a + b; c = (rr > 255); h = ((a % 16) + (b % 16)) > 15; end
            1, 7: begin rr = a - b; c = (a < b); h = (a % 16) < (b % 16); n = 1; end
            2: begin rr = a & b; h = 1; end
            3: rr = a | b;
            4: rr = a ^ b;
            5: begin rr = a + 1; h = (a % 16) == 15; end
            6: begin rr = a - 1; h = (a % 16) == 0; n = 1; end
            default: rr = 0;
        endcase
        r = rr & 255;
        f = {(r == 0), n, h, c};
    endfunction

    task automatic push(input logic [7:0] sel, input logic rw, input logic [7:0] wd, input logic v,
                        input logic [7:0] d, input logic [3:0] f, input logic e, input logic cd,
                        input logic rdy);
        rec_t x;
        x.sel = sel; x.rw = rw; x.wd = wd; x.v = v; x.d = d; x.f = f; x.e = e; x.cd = cd; x.rdy = rdy;
        exp_q.push_back(x);
    endtask

    // Expected per-cycle outputs of one accepted transaction, from the transaction rules
    task automatic model_txn(input int op, input int idx, input int alu, input int wd);
        logic [7:0] oh;
        logic [3:0] f;
        int         r;
        oh = 8'(1 << idx);
        case (op)
            0: begin
                push(oh, 1, 0, 0, 0, 0, 0, 0, 0);
                push(0, 0, 0, 0, 0, 0, 0, 0, 0);
                push(0, 0, 0, 1, mreg[idx], 4'h0, 0, 1, 0);
                last_lat = 3;
            end
            1: begin
                push(oh, 0, 8'(wd), 0, 0, 0, 0, 0, 0);
                push(0, 0, 0, 1, 0, 0, 0, 0, 0);
                mreg[idx] = 8'(wd);
                last_lat = 2;
            end
            2: begin
                m_alu(int'(mreg[idx]), wd, alu, r, f);
                push(oh, 1, 0, 0, 0, 0, 0, 0, 0);
                push(0, 0, 0, 0, 0, 0, 0, 0, 0);
                push(0, 0, 0, 0, 0, 0, 0, 0, 0);
                last_lat = 3;
                if (alu != 7) begin
                    push(oh, 0, 8'(r), 0, 0, 0, 0, 0, 0);
                    last_lat++;
                end
                if (FLG == 1) begin
                    push(8'h80, 0, {f, 4'h0}, 0, 0, 0, 0, 0, 0);
                    last_lat++;
                end
                push(0, 0, 0, 1, (alu == 7) ? mreg[idx] : 8'(r), f, 0, 1, 0);
                last_lat++;
                if (alu != 7) mreg[idx] = 8'(r);
                if (FLG == 1) mreg[7] = {f, 4'h0};
            end
            default: begin
                push(0, 0, 0, 1, 0, 0, 1, 0, 0);
                last_lat = 1;
            end
        endcase
        push(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : cmp
            rec_t x;
            x = exp_q.pop_front();
            chk("sel", 32'(reg_sel), 32'(x.sel));
            if (x.sel != 0) chk("rw", 32'(reg_rw), 32'(x.rw));
            if (x.sel != 0 && !x.rw) chk("wdata", 32'(reg_wdata), 32'(x.wd));
            chk("rsp_valid", 32'(rsp_valid), 32'(x.v));
            if (x.v) chk("rsp_err", 32'(rsp_err), 32'(x.e));
            if (x.v && x.cd) chk("rsp_data", 32'(rsp_data), 32'(x.d));
            if (x.v && x.cd) chk("rsp_flags", 32'(rsp_flags), 32'(x.f));
            chk("ready", 32'(req_ready), 32'(x.rdy));
        end
    end

    // Called at posedge+1; returns just after the accepting edge (+1)
    task automatic issue(input int op, input int idx, input int alu, input int wd, input bit hold);
        bit   acc;
        logic rdy;
        acc = 0;
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_reg   = 3'(idx);
        req_alu   = 3'(alu);
        req_wdata = 8'(wd);
        for (int t = 0; t < 40 && !acc; t++) begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) acc = 1;
        end
        if (!acc) begin
            n_tot++;
            $display("FAIL accept_timeout: request not accepted within 40 cycles");
        end else if (!skip_model) begin
            model_txn(op, idx, alu, wd);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_tot++;
            $display("FAIL drain_timeout: %0d expected cycles left", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int         r;
        logic [3:0] f;
        logic [7:0] old;
        int         x, op, hold;

        rst = 1'b1; bank_load = 1'b1;
        req_valid = 0; req_op = 0; req_reg = 0; req_alu = 0; req_wdata = 0;
        for (int i = 0; i < 8; i++) begin
            seed[i] = 8'($urandom);
            mreg[i] = seed[i];
        end

        m_alu(255, 1, 0, r, f);  chk("m_add_r", r, 0);    chk("m_add_f", f, 4'b1011);
        m_alu(16, 1, 1, r, f);   chk("m_sub_r", r, 15);   chk("m_sub_f", f, 4'b0110);
        m_alu(16, 16, 7, r, f);  chk("m_cp_f", f, 4'b1100);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);   chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);     chk("rst_flags", rsp_flags, 0);
        chk("rst_err", rsp_err, 0);       chk("rst_sel", reg_sel, 0);
        chk("rst_rw", reg_rw, 0);         chk("rst_wdata", reg_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0; bank_load = 1'b0;
        @(posedge clk); #1;

        issue(1, 1, 0, 'h5A, 1);  chk("lat_write", last_lat, 2);
        issue(0, 1, 0, 0, 0);     chk("lat_read", last_lat, 3);
        drain();                  chk("bank_B", regs[1], 8'h5A);

        issue(1, 0, 0, 'hFF, 0);
        issue(2, 0, 0, 'h01, 0);  chk("lat_add", last_lat, 5 + FLG);
        drain();                  chk("bank_A_add", regs[0], 8'h00);
        if (FLG == 1) chk("bank_F_flags", regs[7], 8'hB0);

        issue(1, 0, 0, 'h10, 0);
        issue(2, 0, 1, 'h01, 0);
        drain();                  chk("bank_A_sub", regs[0], 8'h0F);

        issue(1, 0, 0, 'h10, 0);
        issue(2, 0, 7, 'h10, 0);  chk("lat_cp", last_lat, 4 + FLG);
        drain();                  chk("bank_A_cp", regs[0], 8'h10);

        issue(3, 3, 0, 0, 0);     chk("lat_rsvd", last_lat, 1);
        drain();

        // Reset during the write strobe: strobe drops at once, target untouched
        skip_model = 1'b1;
        old = regs[2];
        issue(1, 2, 0, int'(~old), 0);
        chk("wr_stb_sel", reg_sel, 8'h04);
        rst = 1'b1;
        #1;
        chk("rst_async_sel", reg_sel, 0);
        @(posedge clk); #1;
        chk("rst_no_write", regs[2], old);
        @(posedge clk); #1;
        rst = 1'b0;
        skip_model = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", req_ready, 1);
        chk("rst_rel_valid", rsp_valid, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 250; k++) begin
            x    = int'($urandom_range(0, 9));
            op   = (x < 3) ? 0 : (x < 6) ? 1 : (x < 9) ? 2 : 3;
            hold = int'($urandom_range(0, 1));
            issue(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), hold[0]);
            if (hold == 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0;
        drain();
        for (int i = 0; i < 8; i++) chk($sformatf("bank_final_%0d", i), regs[i], mreg[i]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
